xdrs_rc_sched: RTL and testbench

- Reconfiguration scheduler in the static region.
- Accepts reconfiguration requests (region id plus module id) from the host or ICAP front end, one at a time.
- Per request:
  - drives the per-region safe-state handshake (rc_reqn/rc_ackn) towards that region's filter synchroniser;
  - isolates the region and holds it in reset;
  - triggers the bitstream loader and waits for it to finish;
  - releases the region.
- Tracks which module is currently loaded in each region.

---
 rtl/xdrs_rc_pkg.sv | 21 ++
 rtl/xdrs_rc_modtab.sv | 49 ++++
 rtl/xdrs_rc_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_xdrs_rc_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/xdrs_rc_pkg.sv
// Shared types and constants for the reconfiguration scheduler.
package xdrs_rc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    CFG_GO   = 3'd2,
    CFG_WAIT = 3'd3,
    HOLD     = 3'd4,
    DONE     = 3'd5
  } rc_state_t;

  localparam int unsigned CODEW = 2;
  localparam int unsigned HOLDW = 8;

  localparam logic [CODEW-1:0] RC_OK    = 2'd0;
  localparam logic [CODEW-1:0] RC_SKIP  = 2'd1;
  localparam logic [CODEW-1:0] RC_BADRR = 2'd2;
  localparam logic [CODEW-1:0] RC_FAIL  = 2'd3;

endpackage

// File: rtl/xdrs_rc_modtab.sv
// Per-region table of the currently loaded module with a combinational hit lookup.
module xdrs_rc_modtab
  import xdrs_rc_pkg::*;
#(
  parameter int unsigned NUM_RR = 2,
  parameter int unsigned RRW    = 3,
  parameter int unsigned MODW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_clr,
  input  logic [RRW-1:0]  wr_rr,
  input  logic [MODW-1:0] wr_mod,
  input  logic [RRW-1:0]  lk_rr,
  input  logic [MODW-1:0] lk_mod,
  output logic            hit
);

  logic [NUM_RR-1:0] loaded;
  logic [MODW-1:0]   cur_mod [NUM_RR];

  // Region ids are compared rather than used as indices so out-of-range ids never alias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded <= '0;
      for (int i = 0; i < NUM_RR; i++) cur_mod[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RR; i++) begin
        if (wr_rr == RRW'(i)) begin
          if (wr_clr) begin
            loaded[i] <= 1'b0;
          end else if (wr_en) begin
            loaded[i]  <= 1'b1;
            cur_mod[i] <= wr_mod;
          end
        end
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_RR; i++) begin
      if (lk_rr == RRW'(i) && loaded[i] && cur_mod[i] == lk_mod) hit = 1'b1;
    end
  end

endmodule

// File: rtl/xdrs_rc_sched.sv
// Reconfiguration scheduler: safe-state handshake, isolate/reset, loader trigger, release.
// Optional macro RC_TIMEOUT_EN bounds the safe-state wait to TIMEOUT cycles.
module xdrs_rc_sched
  import xdrs_rc_pkg::*;
#(
  parameter int unsigned NUM_RR   = 2,
  parameter int unsigned RRW      = 3,
  parameter int unsigned MODW     = 4,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RRW-1:0]    req_rr,
  input  logic [MODW-1:0]   req_mod,
  output logic [NUM_RR-1:0] rc_reqn,
  input  logic [NUM_RR-1:0] rc_ackn,
  output logic [NUM_RR-1:0] rr_iso,
  output logic [NUM_RR-1:0] rr_rst,
  output logic              cfg_start,
  output logic [RRW-1:0]    cfg_rr,
  output logic [MODW-1:0]   cfg_mod,
  input  logic              cfg_done,
  input  logic              cfg_err,
  output logic              done_valid,
  output logic [CODEW-1:0]  done_code,
  output logic              busy
);

  if (NUM_RR < 1 || NUM_RR > 8 || RST_HOLD < 1 || RST_HOLD > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("xdrs_rc_sched: parameter out of range");
  end

  rc_state_t         state, state_d;
  logic [RRW-1:0]    sel_rr, sel_rr_d;
  logic [MODW-1:0]   sel_mod, sel_mod_d;
  logic [HOLDW-1:0]  hold_cnt, hold_cnt_d;
  logic [CODEW-1:0]  res_code, res_code_d;

  logic              req_ready_d, cfg_start_d, done_valid_d, busy_d;
  logic [NUM_RR-1:0] rc_reqn_d, rr_iso_d, rr_rst_d;
  logic [RRW-1:0]    cfg_rr_d;
  logic [MODW-1:0]   cfg_mod_d;
  logic [CODEW-1:0]  done_code_d;

  logic [NUM_RR-1:0] req_oh, sel_oh;
  logic              bad_rr, ack, tab_hit, tab_wr, tab_clr;

`ifdef RC_TIMEOUT_EN
  logic [31:0] to_cnt, to_cnt_d;
`endif

  always_comb begin
    req_oh = '0;
    sel_oh = '0;
    for (int i = 0; i < NUM_RR; i++) begin
      req_oh[i] = (req_rr == RRW'(i));
      sel_oh[i] = (sel_rr == RRW'(i));
    end
  end

  assign bad_rr = {1'b0, req_rr} >= (RRW+1)'(NUM_RR);
  assign ack    = |(sel_oh & ~rc_ackn);

  xdrs_rc_modtab #(
    .NUM_RR (NUM_RR),
    .RRW    (RRW),
    .MODW   (MODW)
  ) u_modtab (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (tab_wr),
    .wr_clr (tab_clr),
    .wr_rr  (sel_rr),
    .wr_mod (sel_mod),
    .lk_rr  (req_rr),
    .lk_mod (req_mod),
    .hit    (tab_hit)
  );

  always_comb begin
    state_d      = state;
    sel_rr_d     = sel_rr;
    sel_mod_d    = sel_mod;
    hold_cnt_d   = hold_cnt;
    res_code_d   = res_code;
    rc_reqn_d    = rc_reqn;
    rr_iso_d     = rr_iso;
    rr_rst_d     = rr_rst;
    cfg_rr_d     = cfg_rr;
    cfg_mod_d    = cfg_mod;
    done_code_d  = done_code;
    cfg_start_d  = 1'b0;
    done_valid_d = 1'b0;
    tab_wr       = 1'b0;
    tab_clr      = 1'b0;
`ifdef RC_TIMEOUT_EN
    to_cnt_d     = to_cnt;
`endif

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          sel_rr_d  = req_rr;
          sel_mod_d = req_mod;
          if (bad_rr) begin
            state_d      = DONE;
            done_valid_d = 1'b1;
            done_code_d  = RC_BADRR;
          end else if (tab_hit) begin
            state_d      = DONE;
            done_valid_d = 1'b1;
            done_code_d  = RC_SKIP;
          end else begin
            state_d   = REQ;
            rc_reqn_d = rc_reqn & ~req_oh;
`ifdef RC_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
          end
        end
      end
      REQ: begin
        // Ack is acted on the edge it is sampled so a one-cycle pulse is never lost.
        if (ack) begin
          state_d     = CFG_GO;
          rc_reqn_d   = rc_reqn | sel_oh;
          rr_iso_d    = rr_iso | sel_oh;
          rr_rst_d    = rr_rst | sel_oh;
          cfg_start_d = 1'b1;
          cfg_rr_d    = sel_rr;
          cfg_mod_d   = sel_mod;
        end
`ifdef RC_TIMEOUT_EN
        else if (to_cnt == 32'(TIMEOUT - 1)) begin
          state_d      = DONE;
          rc_reqn_d    = rc_reqn | sel_oh;
          done_valid_d = 1'b1;
          done_code_d  = RC_FAIL;
        end else begin
          to_cnt_d = to_cnt + 32'd1;
        end
`endif
      end
      CFG_GO: begin
        state_d = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (cfg_done) begin
          state_d    = HOLD;
          hold_cnt_d = HOLDW'(RST_HOLD - 1);
          res_code_d = cfg_err ? RC_FAIL : RC_OK;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_d      = DONE;
          rr_rst_d     = rr_rst & ~sel_oh;
          rr_iso_d     = rr_iso & ~sel_oh;
          done_valid_d = 1'b1;
          done_code_d  = res_code;
          tab_wr       = (res_code == RC_OK);
          tab_clr      = (res_code != RC_OK);
        end else begin
          hold_cnt_d = hold_cnt - HOLDW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_rr     <= '0;
      sel_mod    <= '0;
      hold_cnt   <= '0;
      res_code   <= RC_OK;
      req_ready  <= 1'b0;
      rc_reqn    <= '1;
      rr_iso     <= '0;
      rr_rst     <= '0;
      cfg_start  <= 1'b0;
      cfg_rr     <= '0;
      cfg_mod    <= '0;
      done_valid <= 1'b0;
      done_code  <= RC_OK;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sel_rr     <= sel_rr_d;
      sel_mod    <= sel_mod_d;
      hold_cnt   <= hold_cnt_d;
      res_code   <= res_code_d;
      req_ready  <= req_ready_d;
      rc_reqn    <= rc_reqn_d;
      rr_iso     <= rr_iso_d;
      rr_rst     <= rr_rst_d;
      cfg_start  <= cfg_start_d;
      cfg_rr     <= cfg_rr_d;
      cfg_mod    <= cfg_mod_d;
      done_valid <= done_valid_d;
      done_code  <= done_code_d;
      busy       <= busy_d;
    end
  end

`ifdef RC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt <= '0;
    else     to_cnt <= to_cnt_d;
  end
`endif

endmodule

// File: tb/tb_xdrs_rc_sched.sv
// Scoreboard bench for xdrs_rc_sched; also covers the RC_TIMEOUT_EN build.
module tb_xdrs_rc_sched;

  localparam int unsigned NR   = 2;
  localparam int unsigned RRW  = 3;
  localparam int unsigned MODW = 4;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [RRW-1:0]  req_rr;
  logic [MODW-1:0] req_mod;
  logic [NR-1:0]   rc_reqn;
  logic [NR-1:0]   rc_ackn;
  logic [NR-1:0]   rr_iso;
  logic [NR-1:0]   rr_rst;
  logic            cfg_start;
  logic [RRW-1:0]  cfg_rr;
  logic [MODW-1:0] cfg_mod;
  logic            cfg_done;
  logic            cfg_err;
  logic            done_valid;
  logic [1:0]      done_code;
  logic            busy;

  xdrs_rc_sched #(
    .NUM_RR(NR), .RRW(RRW), .MODW(MODW), .RST_HOLD(HOLD), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rr(req_rr), .req_mod(req_mod),
    .rc_reqn(rc_reqn), .rc_ackn(rc_ackn), .rr_iso(rr_iso), .rr_rst(rr_rst),
    .cfg_start(cfg_start), .cfg_rr(cfg_rr), .cfg_mod(cfg_mod),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .done_valid(done_valid), .done_code(done_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int starts = 0;
  logic [1:0] exp_done[$];
  logic [6:0] exp_cfg[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops expected completions and loader commands as the DUT presents them.
  always @(negedge clk) begin
    if (done_valid === 1'b1) begin
      if (exp_done.size() == 0) chk("done_unexpected", 32'(done_code), 32'hDEAD);
      else chk("done_code", 32'(done_code), 32'(exp_done.pop_front()));
    end
    if (cfg_start === 1'b1) begin
      starts++;
      if (exp_cfg.size() == 0) chk("cfg_unexpected", 32'({cfg_rr, cfg_mod}), 32'hDEAD);
      else chk("cfg_cmd", 32'({cfg_rr, cfg_mod}), 32'(exp_cfg.pop_front()));
    end
  end

  task automatic send(input int rr, input int md);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_rr    = RRW'(rr);
    req_mod   = MODW'(md);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Full handshake/load sequence; abort pulses rst during CFG_WAIT instead of finishing.
  task automatic do_load(input int rr, input int md, input bit err, input bit spurious, input bit abort);
    logic [NR-1:0] m, nm;
    int n;
    m  = NR'(1) << rr;
    nm = ~m;
    if (!abort) exp_done.push_back(err ? 2'd3 : 2'd0);
    exp_cfg.push_back({RRW'(rr), MODW'(md)});
    send(rr, md);
    chk("reqn_low", 32'(rc_reqn), 32'(nm));
    chk("busy_req", 32'(busy), 1);
    repeat (4) @(negedge clk);
    chk("rst_before_ack", 32'(rr_rst), 0);
    rc_ackn = nm;
    @(negedge clk);
    rc_ackn = '1;
    chk("rst_after_ack", 32'(rr_rst), 32'(m));
    chk("iso_after_ack", 32'(rr_iso), 32'(m));
    chk("reqn_release", 32'(rc_reqn), 32'(2'b11));
    chk("cfg_start_pulse", 32'(cfg_start), 1);
    if (spurious) cfg_done = 1'b1;
    @(negedge clk);
    cfg_done = 1'b0;
    if (abort) begin
      #2 rst = 1'b1;
      #1;
      chk("abort_rr_rst", 32'(rr_rst), 0);
      chk("abort_rr_iso", 32'(rr_iso), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_reqn", 32'(rc_reqn), 32'(2'b11));
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    repeat (8) @(negedge clk);
    chk("rst_held_wait", 32'(rr_rst), 32'(m));
    cfg_done = 1'b1;
    cfg_err  = err;
    @(negedge clk);
    cfg_done = 1'b0;
    cfg_err  = 1'b0;
    n = 0;
    while ((rr_rst & m) != '0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("hold_cycles", 32'(n), HOLD);
    chk("iso_released", 32'(rr_iso), 0);
    chk("done_after_hold", 32'(done_valid), 1);
  endtask

  task automatic quick(input int rr, input int md, input logic [1:0] code);
    int s0;
    s0 = starts;
    exp_done.push_back(code);
    send(rr, md);
    chk("quick_latency", 32'(done_valid), 1);
    chk("quick_reqn", 32'(rc_reqn), 32'(2'b11));
    chk("quick_rr_rst", 32'(rr_rst), 0);
    chk("quick_iso", 32'(rr_iso), 0);
    chk("quick_ready_low", 32'(req_ready), 0);
    @(negedge clk);
    chk("quick_no_start", 32'(starts), 32'(s0));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rr = '0; req_mod = '0;
    rc_ackn = '1; cfg_done = 1'b0; cfg_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_reqn", 32'(rc_reqn), 32'(2'b11));
    chk("rst_iso", 32'(rr_iso), 0);
    chk("rst_rr_rst", 32'(rr_rst), 0);
    chk("rst_ctl", 32'({cfg_start, done_valid, busy, req_ready}), 0);
    chk("rst_code", 32'(done_code), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 1);

    do_load(1, 3, 1'b0, 1'b0, 1'b0);   // basic load
    quick(1, 3, 2'd1);                 // skip
    quick(5, 2, 2'd2);                 // bad region
    do_load(0, 7, 1'b1, 1'b0, 1'b0);   // loader failure
    do_load(0, 7, 1'b0, 1'b1, 1'b0);   // retry runs fully; cfg_done in CFG_GO ignored
    quick(0, 7, 2'd1);
    quick(1, 3, 2'd1);

    // Isolation: only region 0 acks; region 1 must not progress.
    begin
      int s0, n;
      logic [NR-1:0] rst_seen;
      s0 = starts;
      rc_ackn = 2'b10;
`ifdef RC_TIMEOUT_EN
      exp_done.push_back(2'd3);
`endif
      send(1, 9);
      rst_seen = '0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        rst_seen |= rr_rst;
        n++;
        @(negedge clk);
      end
      chk("iso_no_rst", 32'(rst_seen), 0);
      chk("iso_no_start", 32'(starts), 32'(s0));
`ifdef RC_TIMEOUT_EN
      chk("iso_timeout_cycles", 32'(n), TOUT + 1);
      chk("iso_reqn_released", 32'(rc_reqn), 32'(2'b11));
`else
      chk("iso_still_busy", 32'(busy), 1);
      chk("iso_reqn_held", 32'(rc_reqn), 32'(2'b01));
`endif
      rc_ackn = '1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end

    do_load(1, 3, 1'b0, 1'b0, 1'b0);   // table was cleared by reset
    do_load(0, 4, 1'b0, 1'b0, 1'b1);   // reset mid-CFG_WAIT
    do_load(1, 3, 1'b0, 1'b0, 1'b0);   // not skipped after reset

    repeat (5) @(negedge clk);
    chk("done_queue_empty", 32'(exp_done.size()), 0);
    chk("cfg_queue_empty", 32'(exp_cfg.size()), 0);
    chk("cfg_start_count", 32'(starts), 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
